// File: rtl/pipe_ctrl_pkg.sv
// Shared types and encodings for the pipeline sequencing controller.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
// Contents: memory wait FSM state enum, forwarding-select encodings,
// the load result-select code, and the per-operand forwarding function.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } mem_state_e;

  localparam logic [1:0] FWD_RF      = 2'b00;
  localparam logic [1:0] FWD_WB      = 2'b01;
  localparam logic [1:0] FWD_MEM     = 2'b10;
  localparam logic [1:0] RESULT_LOAD = 2'b01;

  // Per-operand bypass select. MEM is checked first so the younger
  // producer wins when both later stages write the same register.
  function automatic logic [1:0] fwd_sel(
    input logic       we_m,
    input logic [4:0] rd_m,
    input logic       we_w,
    input logic [4:0] rd_w,
    input logic [4:0] rs
  );
    if (we_m && (rd_m != 5'd0) && (rd_m == rs)) return FWD_MEM;
    if (we_w && (rd_w != 5'd0) && (rd_w == rs)) return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of hazard-unit inputs from the datapath and the stall/flush/forward
// controls returned to it. Latency: n/a. Backpressure: n/a.
// Modports: master = datapath side (drives register ids, write enables,
// memory handshake; receives controls), slave = hazard controller side.
interface pipeline_hazard_ctrl_if;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0]  ResultSrcE;
  logic        RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        StallF, StallD, StallE, StallM;
  logic        FlushD, FlushE, FlushW;
  logic        MemErr;
  logic [31:0] PerfStall, PerfFlush;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE,
           RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
           FlushD, FlushE, FlushW, MemErr, PerfStall, PerfFlush
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE,
           RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
           FlushD, FlushE, FlushW, MemErr, PerfStall, PerfFlush
  );
endinterface

// File: rtl/mem_wait_fsm.sv
// Data-memory wait-state tracker with timeout trap.
// Latency: mem_stall is combinational (first not-ready cycle stalls); mem_err registered.
// Backpressure: mem_stall holds the pipeline while memory is not ready; ERR stalls forever.
// Ports: clk, reset (async active-high), mem_req, mem_ready -> mem_stall, mem_err.
module mem_wait_fsm
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic mem_req,
  input  logic mem_ready,
  output logic mem_stall,
  output logic mem_err
);

  mem_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_err_q, mem_err_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_stall = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_req && !mem_ready) begin
          mem_stall = 1'b1;
          state_d   = WAIT;
          cnt_d     = CNT_W'(1);
        end
      end
      WAIT: begin
        // A request that vanishes mid-wait is treated as a completion so
        // the pipeline is never left frozen by a confused requester.
        if (mem_ready || !mem_req) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          mem_stall = 1'b1;
          if (cnt_q == CNT_W'(MEM_TIMEOUT)) begin
            state_d = ERR;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ERR: begin
        mem_stall = 1'b1;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    mem_err_d = (state_d == ERR);
  end

  assign mem_err = mem_err_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forward sequencing for the 5-stage RV32I pipeline registers.
// Latency: all controls combinational off inputs and FSM state; MemErr registered.
// Backpressure: memory not-ready freezes F..M and bubbles MEM/WB; load-use holds F/D.
// Ports: clk, reset (async active-high), hz (slave modport: register ids, write
// enables, ResultSrcE, PCSrcE, MemReqM/MemReadyM in; Forward*, Stall*, Flush*,
// MemErr, PerfStall/PerfFlush out). Optional macro HAZARD_PERF_CNT_EN enables
// the 32-bit stall/flush event counters; otherwise they read 0.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  pipeline_hazard_ctrl_if.slave hz
);

  logic lw_stall;
  logic mem_stall;
  logic stall_fd;
  logic flush_d;
  logic flush_e;

  mem_wait_fsm #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) u_mem_wait_fsm (
    .clk       (clk),
    .reset     (reset),
    .mem_req   (hz.MemReqM),
    .mem_ready (hz.MemReadyM),
    .mem_stall (mem_stall),
    .mem_err   (hz.MemErr)
  );

  always_comb begin
    lw_stall = (hz.ResultSrcE == RESULT_LOAD) && (hz.RdE != 5'd0) &&
               ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
  end

  assign hz.ForwardAE = fwd_sel(hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW, hz.Rs1E);
  assign hz.ForwardBE = fwd_sel(hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW, hz.Rs2E);

  // A memory stall masks flushes: E is frozen, so a taken branch stays
  // presented and is acted on in the first cycle after the stall clears.
  assign stall_fd  = lw_stall | mem_stall;
  assign flush_d   = hz.PCSrcE & ~mem_stall;
  assign flush_e   = (lw_stall | hz.PCSrcE) & ~mem_stall;

  assign hz.StallF = stall_fd;
  assign hz.StallD = stall_fd;
  assign hz.StallE = mem_stall;
  assign hz.StallM = mem_stall;
  assign hz.FlushW = mem_stall;
  assign hz.FlushD = flush_d;
  assign hz.FlushE = flush_e;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  always_comb begin
    perf_stall_d = perf_stall_q + {31'd0, stall_fd};
    perf_flush_d = perf_flush_q + {31'd0, (flush_d | flush_e)};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign hz.PerfStall = perf_stall_q;
  assign hz.PerfFlush = perf_flush_q;
`else
  assign hz.PerfStall = 32'd0;
  assign hz.PerfFlush = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  pipeline_hazard_ctrl_if bus ();

  pipeline_hazard_ctrl #(
    .MEM_TIMEOUT (4),
    .CNT_W       (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (bus)
  );

  // {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
  wire [6:0] ctl = {bus.StallF, bus.StallD, bus.StallE, bus.StallM,
                    bus.FlushD, bus.FlushE, bus.FlushW};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.Rs1D = 5'd0; bus.Rs2D = 5'd0; bus.Rs1E = 5'd0; bus.Rs2E = 5'd0;
    bus.RdE = 5'd0; bus.RdM = 5'd0; bus.RdW = 5'd0; bus.ResultSrcE = 2'b00;
    bus.RegWriteM = 1'b0; bus.RegWriteW = 1'b0; bus.PCSrcE = 1'b0;
    bus.MemReqM = 1'b0; bus.MemReadyM = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive_idle();
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_idle();
    #2;
    checks++;
    if (bus.MemErr !== 1'b0) begin errors++; $display("FAIL reset_memerr got %b want 0", bus.MemErr); end
    checks++;
    if (ctl !== 7'b0000000) begin errors++; $display("FAIL reset_ctl got %b want 0000000", ctl); end
    checks++;
    if ({bus.ForwardAE, bus.ForwardBE} !== 4'b0000) begin
      errors++; $display("FAIL reset_fwd got %b want 0000", {bus.ForwardAE, bus.ForwardBE});
    end
    checks++;
    if ({bus.PerfStall, bus.PerfFlush} !== 64'd0) begin
      errors++; $display("FAIL reset_perf got %0d/%0d want 0/0", bus.PerfStall, bus.PerfFlush);
    end
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_forwarding();
    drive_idle();
    bus.RdM = 5'd5; bus.RegWriteM = 1'b1; bus.RdW = 5'd5; bus.RegWriteW = 1'b1; bus.Rs1E = 5'd5;
    #1;
    checks++;
    if (bus.ForwardAE !== 2'b10) begin errors++; $display("FAIL fwd_mem_prio got %b want 10", bus.ForwardAE); end
    bus.RdM = 5'd0;
    #1;
    checks++;
    if (bus.ForwardAE !== 2'b01) begin errors++; $display("FAIL fwd_rdm0_wb got %b want 01", bus.ForwardAE); end
    bus.RdM = 5'd5; bus.RegWriteM = 1'b0;
    #1;
    checks++;
    if (bus.ForwardAE !== 2'b01) begin errors++; $display("FAIL fwd_nowe_m got %b want 01", bus.ForwardAE); end
    // B operand from MEM while A points elsewhere
    bus.RegWriteM = 1'b1; bus.RdM = 5'd9; bus.Rs2E = 5'd9; bus.Rs1E = 5'd3; bus.RdW = 5'd4;
    #1;
    checks++;
    if ({bus.ForwardAE, bus.ForwardBE} !== 4'b0010) begin
      errors++; $display("FAIL fwd_b_mem got %b want 0010", {bus.ForwardAE, bus.ForwardBE});
    end
    // x0 is never forwarded even when ids match
    bus.RdM = 5'd0; bus.RdW = 5'd0; bus.Rs1E = 5'd0; bus.Rs2E = 5'd0;
    #1;
    checks++;
    if ({bus.ForwardAE, bus.ForwardBE} !== 4'b0000) begin
      errors++; $display("FAIL fwd_x0 got %b want 0000", {bus.ForwardAE, bus.ForwardBE});
    end
    bus.RdW = 5'd12; bus.Rs2E = 5'd12;
    #1;
    checks++;
    if (bus.ForwardBE !== 2'b01) begin errors++; $display("FAIL fwd_b_wb got %b want 01", bus.ForwardBE); end
    drive_idle();
  endtask

  task automatic test_load_use();
    drive_idle();
    bus.ResultSrcE = 2'b01; bus.RdE = 5'd7; bus.Rs2D = 5'd7;
    #1;
    checks++;
    if (ctl !== 7'b1100010) begin errors++; $display("FAIL lw_stall got %b want 1100010", ctl); end
    bus.RdE = 5'd0; bus.Rs2D = 5'd0;
    #1;
    checks++;
    if (ctl !== 7'b0000000) begin errors++; $display("FAIL lw_rd0 got %b want 0000000", ctl); end
    bus.ResultSrcE = 2'b00; bus.RdE = 5'd7; bus.Rs1D = 5'd7;
    #1;
    checks++;
    if (ctl !== 7'b0000000) begin errors++; $display("FAIL lw_notload got %b want 0000000", ctl); end
    bus.ResultSrcE = 2'b01;
    #1;
    checks++;
    if (ctl !== 7'b1100010) begin errors++; $display("FAIL lw_rs1 got %b want 1100010", ctl); end
    bus.PCSrcE = 1'b1;
    #1;
    checks++;
    if (ctl !== 7'b1100110) begin errors++; $display("FAIL lw_and_branch got %b want 1100110", ctl); end
    drive_idle();
  endtask

  task automatic test_mem_wait();
    drive_idle();
    bus.MemReqM = 1'b1; bus.MemReadyM = 1'b1;
    #1;
    checks++;
    if (ctl !== 7'b0000000) begin errors++; $display("FAIL mem_ready_same_cycle got %b want 0000000", ctl); end
    bus.MemReadyM = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (ctl !== 7'b1111001) begin errors++; $display("FAIL mem_wait_cyc%0d got %b want 1111001", i, ctl); end
      tick();
    end
    bus.MemReadyM = 1'b1;
    #1;
    checks++;
    if (ctl !== 7'b0000000) begin errors++; $display("FAIL mem_release got %b want 0000000", ctl); end
    tick();
    bus.MemReqM = 1'b0; bus.MemReadyM = 1'b0;
    #1;
    checks++;
    if ({ctl, bus.MemErr} !== 8'h00) begin errors++; $display("FAIL mem_after got %b want 00000000", {ctl, bus.MemErr}); end
    // dropping the request mid-wait behaves as a completion
    bus.MemReqM = 1'b1;
    tick();
    bus.MemReqM = 1'b0;
    #1;
    checks++;
    if (ctl !== 7'b0000000) begin errors++; $display("FAIL mem_req_drop got %b want 0000000", ctl); end
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    bus.MemReqM = 1'b1; bus.MemReadyM = 1'b0;
    // WAIT with counter 1..4 after edges 1..4; the 5th edge enters ERR
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++;
      if (bus.MemErr !== (i == 5)) begin errors++; $display("FAIL timeout_edge%0d got %b want %b", i, bus.MemErr, (i == 5)); end
    end
    bus.MemReqM = 1'b0; bus.MemReadyM = 1'b1; bus.PCSrcE = 1'b1;
    tick();
    checks++;
    if ({ctl, bus.MemErr} !== 8'b11110011) begin
      errors++; $display("FAIL err_sticky got %b want 11110011", {ctl, bus.MemErr});
    end
    bus.PCSrcE = 1'b0; bus.MemReadyM = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if ({ctl, bus.MemErr} !== 8'h00) begin errors++; $display("FAIL err_async_reset got %b want 00000000", {ctl, bus.MemErr}); end
    tick();
    reset = 1'b0;
    bus.MemReqM = 1'b1; bus.MemReadyM = 1'b1;
    #1;
    checks++;
    if (ctl !== 7'b0000000) begin errors++; $display("FAIL idle_after_reset got %b want 0000000", ctl); end
    drive_idle();
    tick();
  endtask

  task automatic test_branch_during_stall();
    drive_idle();
    bus.MemReqM = 1'b1; bus.MemReadyM = 1'b0; bus.PCSrcE = 1'b1;
    #1;
    checks++;
    if (ctl !== 7'b1111001) begin errors++; $display("FAIL branch_in_stall got %b want 1111001", ctl); end
    tick();
    bus.MemReadyM = 1'b1;
    #1;
    checks++;
    if (ctl !== 7'b0000110) begin errors++; $display("FAIL branch_after_stall got %b want 0000110", ctl); end
    drive_idle();
    tick();
  endtask

  task automatic test_perf();
    logic [31:0] exp_ps;
    logic [31:0] exp_pf;
`ifdef HAZARD_PERF_CNT_EN
    exp_ps = 32'd3;
    exp_pf = 32'd1;
`else
    exp_ps = 32'd0;
    exp_pf = 32'd0;
`endif
    do_reset();
    bus.MemReqM = 1'b1; bus.MemReadyM = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    bus.MemReadyM = 1'b1;
    tick();
    bus.MemReqM = 1'b0; bus.MemReadyM = 1'b0; bus.PCSrcE = 1'b1;
    tick();
    bus.PCSrcE = 1'b0;
    tick();
    checks++;
    if (bus.PerfStall !== exp_ps) begin errors++; $display("FAIL perf_stall got %0d want %0d", bus.PerfStall, exp_ps); end
    checks++;
    if (bus.PerfFlush !== exp_pf) begin errors++; $display("FAIL perf_flush got %0d want %0d", bus.PerfFlush, exp_pf); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    test_reset();
    test_forwarding();
    test_load_use();
    test_mem_wait();
    test_timeout();
    test_branch_during_stall();
    test_perf();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
